// File: rtl/step_seq_pkg.sv
// Shared types for the adaptive-step ODE sequencer: FSM state encoding and fail codes.
package step_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_READ,
        ST_CAPTURE,
        ST_FINISH,
        ST_FAIL
    } state_e;

    localparam logic [1:0] FAIL_NONE     = 2'd0;
    localparam logic [1:0] FAIL_RETRY    = 2'd1;
    localparam logic [1:0] FAIL_SM_ERROR = 2'd2;
    localparam logic [1:0] FAIL_TIMEOUT  = 2'd3;

endpackage

// File: rtl/wait_watchdog.sv
// Saturating cycle counter for the WAIT state; expired_o flags TIMEOUT_CYCLES elapsed.
module wait_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired_q, expired_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + CW'(1);
        end
        expired_d = (cnt_d == CW'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/step_sequencer.sv
// Adaptive-step integration controller: drives StepModule, accepts/retries steps,
// advances time, ping-pongs state buffers and clips the last step onto t_end.
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned ADDRESS_WIDTH  = 4,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ITER_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic [WORD_SIZE-1:0]     h_init,
    input  logic [WORD_SIZE-1:0]     t_end,
    input  logic [ADDRESS_WIDTH-1:0] buf_a_addr,
    input  logic [ADDRESS_WIDTH-1:0] buf_b_addr,
    output logic                     sm_init,
    output logic                     sm_start,
    output logic                     sm_read_step,
    output logic [WORD_SIZE-1:0]     sm_step_in,
    output logic [ADDRESS_WIDTH-1:0] x0_address,
    output logic [ADDRESS_WIDTH-1:0] x1_address,
    input  logic                     sm_done,
    input  logic                     sm_proceed,
    input  logic                     sm_error,
    input  logic [WORD_SIZE-1:0]     sm_step_out,
    output logic [WORD_SIZE-1:0]     t_now,
    output logic [ITER_WIDTH-1:0]    iter_count,
    output logic                     busy,
    output logic                     finished,
    output logic                     fail,
    output logic [1:0]               fail_code
);

    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    state_e                   state_q, state_d;
    logic [WORD_SIZE-1:0]     h_cur_q, h_cur_d;
    logic [WORD_SIZE-1:0]     t_end_q, t_end_d;
    logic [WORD_SIZE-1:0]     t_now_q, t_now_d;
    logic [ITER_WIDTH-1:0]    iter_q, iter_d;
    logic [RW-1:0]            retry_q, retry_d;
    logic [ADDRESS_WIDTH-1:0] x0_q, x0_d, x1_q, x1_d;
    logic [WORD_SIZE-1:0]     step_in_q, step_in_d;
    logic [1:0]               code_q, code_d;
    logic                     init_q, init_d, start_q, start_d, read_q, read_d;
    logic                     busy_q, busy_d, fin_q, fin_d, fail_q, fail_d;

    logic                     wd_clear, wd_en, wd_expired;
    logic [WORD_SIZE:0]       acc_sum, cap_sum;

    wait_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst),
        .clear_i   (wd_clear),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    // One extra bit keeps time sums from wrapping before compare/saturate
    assign acc_sum = {1'b0, t_now_q} + {1'b0, h_cur_q};
    assign cap_sum = {1'b0, t_now_q} + {1'b0, sm_step_out};

    always_comb begin
        state_d   = state_q;
        h_cur_d   = h_cur_q;
        t_end_d   = t_end_q;
        t_now_d   = t_now_q;
        iter_d    = iter_q;
        retry_d   = retry_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        step_in_d = step_in_q;
        code_d    = code_q;
        busy_d    = busy_q;
        fin_d     = fin_q;
        fail_d    = fail_q;
        wd_clear  = 1'b0;
        wd_en     = 1'b0;

        case (state_q)
            ST_IDLE, ST_FINISH, ST_FAIL: begin
                if (go) begin
                    t_end_d = t_end;
                    h_cur_d = h_init;
                    x0_d    = buf_a_addr;
                    x1_d    = buf_b_addr;
                    t_now_d = '0;
                    iter_d  = '0;
                    retry_d = '0;
                    code_d  = FAIL_NONE;
                    fin_d   = 1'b0;
                    fail_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_START;
            ST_START: begin
                wd_clear = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                if (wd_expired) begin
                    code_d  = FAIL_TIMEOUT;
                    state_d = ST_FAIL;
                end else if (sm_done) begin
                    if (sm_error) begin
                        code_d  = FAIL_SM_ERROR;
                        state_d = ST_FAIL;
                    end else if (sm_proceed) begin
                        t_now_d = acc_sum[WORD_SIZE] ? {WORD_SIZE{1'b1}}
                                                     : acc_sum[WORD_SIZE-1:0];
                        iter_d  = (iter_q == {ITER_WIDTH{1'b1}}) ? iter_q
                                                                 : iter_q + ITER_WIDTH'(1);
                        x0_d    = x1_q;
                        x1_d    = x0_q;
                        retry_d = '0;
                        state_d = ST_READ;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        if (retry_q >= RW'(MAX_RETRY)) begin
                            code_d  = FAIL_RETRY;
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_READ: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (t_now_q >= t_end_q) begin
                    state_d = ST_FINISH;
                end else if (cap_sum > {1'b0, t_end_q}) begin
                    h_cur_d = t_end_q - t_now_q;
                    state_d = ST_LOAD;
                end else if (sm_step_out == '0) begin
                    code_d  = FAIL_RETRY;
                    state_d = ST_FAIL;
                end else begin
                    h_cur_d = sm_step_out;
                    state_d = ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Terminal-state status flags, set on entry and held until the next go
        if (state_d == ST_FINISH && state_q != ST_FINISH) begin
            fin_d  = 1'b1;
            busy_d = 1'b0;
        end
        if (state_d == ST_FAIL && state_q != ST_FAIL) begin
            fail_d = 1'b1;
            busy_d = 1'b0;
        end

        // Pulses line up with the state they belong to
        init_d  = (state_d == ST_LOAD);
        start_d = (state_d == ST_START);
        read_d  = (state_d == ST_READ);
        if (state_d == ST_LOAD) begin
            step_in_d = h_cur_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            h_cur_q   <= '0;
            t_end_q   <= '0;
            t_now_q   <= '0;
            iter_q    <= '0;
            retry_q   <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            step_in_q <= '0;
            code_q    <= FAIL_NONE;
            init_q    <= 1'b0;
            start_q   <= 1'b0;
            read_q    <= 1'b0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_cur_q   <= h_cur_d;
            t_end_q   <= t_end_d;
            t_now_q   <= t_now_d;
            iter_q    <= iter_d;
            retry_q   <= retry_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            step_in_q <= step_in_d;
            code_q    <= code_d;
            init_q    <= init_d;
            start_q   <= start_d;
            read_q    <= read_d;
            busy_q    <= busy_d;
            fin_q     <= fin_d;
            fail_q    <= fail_d;
        end
    end

    assign sm_init      = init_q;
    assign sm_start     = start_q;
    assign sm_read_step = read_q;
    assign sm_step_in   = step_in_q;
    assign x0_address   = x0_q;
    assign x1_address   = x1_q;
    assign t_now        = t_now_q;
    assign iter_count   = iter_q;
    assign busy         = busy_q;
    assign finished     = fin_q;
    assign fail         = fail_q;
    assign fail_code    = code_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: scripted StepModule stub plus a sequential reference
// model of the integration loop, with directed and randomized runs.
module tb_step_sequencer;

    localparam int DEPTH     = 512;
    localparam int MAX_RETRY = 3;
    localparam int V_OK      = 0;
    localparam int V_REJ     = 1;
    localparam int V_ERR     = 2;
    localparam int V_NEVER   = 3;

    logic        clk, rst, go;
    logic [15:0] h_init, t_end;
    logic [3:0]  buf_a, buf_b;
    logic        sm_init, sm_start, sm_read_step;
    logic [15:0] sm_step_in;
    logic [3:0]  x0_address, x1_address;
    logic        sm_done, sm_proceed, sm_error;
    logic [15:0] sm_step_out;
    logic [15:0] t_now;
    logic [7:0]  iter_count;
    logic        busy, finished, fail;
    logic [1:0]  fail_code;

    step_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .h_init       (h_init),
        .t_end        (t_end),
        .buf_a_addr   (buf_a),
        .buf_b_addr   (buf_b),
        .sm_init      (sm_init),
        .sm_start     (sm_start),
        .sm_read_step (sm_read_step),
        .sm_step_in   (sm_step_in),
        .x0_address   (x0_address),
        .x1_address   (x1_address),
        .sm_done      (sm_done),
        .sm_proceed   (sm_proceed),
        .sm_error     (sm_error),
        .sm_step_out  (sm_step_out),
        .t_now        (t_now),
        .iter_count   (iter_count),
        .busy         (busy),
        .finished     (finished),
        .fail         (fail),
        .fail_code    (fail_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Stub script: per-attempt verdict, step returned on read, done latency
    int verd [DEPTH];
    int stp  [DEPTH];
    int lat  [DEPTH];

    // Stub observations per attempt (captured at each sm_start)
    int rec_h [DEPTH];
    int rec_t [DEPTH];
    int rec_x0[DEPTH];
    int rec_x1[DEPTH];
    int rec_cyc[DEPTH];
    int rec_n, init_cnt;

    // Reference model results
    int exp_h [DEPTH];
    int exp_t0[DEPTH];
    int exp_sw[DEPTH];
    int exp_clip[DEPTH];
    int exp_n, exp_t, exp_iter, exp_swaps, exp_inits, exp_status, exp_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // StepModule stand-in: holds the step, answers starts after a scripted delay
    initial begin : stub
        int rd_idx, wcnt, cur, cyc;
        logic prev_busy;
        logic [15:0] held;
        sm_done = 1'b0; sm_proceed = 1'b0; sm_error = 1'b0; sm_step_out = '0;
        rd_idx = 0; wcnt = 0; cur = 0; cyc = 0; prev_busy = 1'b0; held = '0;
        rec_n = 0; init_cnt = 0;
        forever begin
            @(negedge clk);
            sm_done = 1'b0; sm_proceed = 1'b0; sm_error = 1'b0;
            cyc++;
            if (busy && !prev_busy) begin
                rec_n = 0; rd_idx = 0; init_cnt = 0; wcnt = 0;
            end
            prev_busy = busy;
            if (!rst) wcnt = 0;
            if (sm_init) begin
                init_cnt++;
                held = sm_step_in;
            end
            if (sm_read_step && rd_idx < DEPTH) begin
                held        = 16'(stp[rd_idx]);
                sm_step_out = 16'(stp[rd_idx]);
                rd_idx++;
            end
            if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0 && verd[cur] != V_NEVER) begin
                    sm_done    = 1'b1;
                    sm_proceed = (verd[cur] == V_OK) || (verd[cur] == V_ERR);
                    sm_error   = (verd[cur] == V_ERR);
                end
            end
            if (sm_start && rec_n < DEPTH) begin
                cur            = rec_n;
                rec_h[rec_n]   = int'(held);
                rec_t[rec_n]   = int'(t_now);
                rec_x0[rec_n]  = int'(x0_address);
                rec_x1[rec_n]  = int'(x1_address);
                rec_cyc[rec_n] = cyc;
                rec_n++;
                wcnt = lat[cur];
            end
        end
    end

    // Integration loop written directly from the accept/retry/clip rules
    task automatic model(input int hi, input int te);
        int t, h, it, rt, sw, ini, n, s;
        bit stop;
        t = 0; h = hi; it = 0; rt = 0; sw = 0; ini = 1; n = 0; stop = 0;
        exp_status = 0; exp_code = 0;
        while (!stop && n < DEPTH) begin
            exp_h[n] = h; exp_t0[n] = t; exp_sw[n] = sw; exp_clip[n] = 0;
            if (verd[n] == V_NEVER) begin
                exp_status = 2; exp_code = 3; stop = 1;
            end else if (verd[n] == V_ERR) begin
                exp_status = 2; exp_code = 2; stop = 1;
            end else if (verd[n] == V_OK) begin
                t  = t + h;
                it = (it < 255) ? it + 1 : it;
                sw = sw + 1;
                rt = 0;
            end else begin
                rt = rt + 1;
                if (rt > MAX_RETRY) begin
                    exp_status = 2; exp_code = 1; stop = 1;
                end
            end
            if (!stop) begin
                s = stp[n];
                if (t >= te) begin
                    exp_status = 1; stop = 1;
                end else if (t + s > te) begin
                    h = te - t; ini = ini + 1; exp_clip[n] = 1;
                end else if (s == 0) begin
                    exp_status = 2; exp_code = 1; stop = 1;
                end else begin
                    h = s;
                end
            end
            n++;
        end
        exp_n = n; exp_t = t; exp_iter = it; exp_swaps = sw; exp_inits = ini;
    endtask

    task automatic fill(input int v, input int s, input int l);
        for (int i = 0; i < DEPTH; i++) begin
            verd[i] = v; stp[i] = s; lat[i] = l;
        end
    endtask

    task automatic run_case(input string name, input int hi, input int te, input bit glitch);
        int cycles;
        int ea, eb;
        model(hi, te);
        h_init = 16'(hi);
        t_end  = 16'(te);
        buf_a  = 4'($urandom_range(1, 15));
        buf_b  = buf_a + 4'($urandom_range(1, 14));
        ea = int'(buf_a);
        eb = int'(buf_b);
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        check({name, ".start_busy"}, 32'(busy), 32'd1);
        check({name, ".start_t"}, 32'(t_now), 32'd0);
        check({name, ".start_status"}, {30'd0, finished, fail}, 32'd0);
        cycles = 0;
        while (!(finished || fail) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (glitch && cycles == 8) begin
                go = 1'b1; h_init = 16'(hi + 3); t_end = 16'(te + 7);
                buf_a = ~buf_a;
            end else if (glitch && cycles == 9) begin
                go = 1'b0; h_init = 16'(hi); t_end = 16'(te);
            end
        end
        check({name, ".completes"}, 32'(cycles < 3000), 32'd1);
        check({name, ".finished"}, 32'(finished), 32'(exp_status == 1));
        check({name, ".fail"}, 32'(fail), 32'(exp_status == 2));
        check({name, ".busy"}, 32'(busy), 32'd0);
        check({name, ".fail_code"}, 32'(fail_code), 32'(exp_code));
        check({name, ".t_now"}, 32'(t_now), 32'(exp_t));
        check({name, ".iter"}, 32'(iter_count), 32'(exp_iter));
        check({name, ".inits"}, 32'(init_cnt), 32'(exp_inits));
        check({name, ".attempts"}, 32'(rec_n), 32'(exp_n));
        check({name, ".x0_final"}, 32'(x0_address), 32'((exp_swaps % 2) ? eb : ea));
        check({name, ".x1_final"}, 32'(x1_address), 32'((exp_swaps % 2) ? ea : eb));
        if (exp_code == 3)
            check({name, ".timeout_window"}, 32'(cycles >= 255 && cycles <= 270), 32'd1);
        for (int i = 0; i < exp_n && i < rec_n; i++) begin
            check($sformatf("%s.h[%0d]", name, i), 32'(rec_h[i]), 32'(exp_h[i]));
            check($sformatf("%s.t[%0d]", name, i), 32'(rec_t[i]), 32'(exp_t0[i]));
            check($sformatf("%s.x0[%0d]", name, i), 32'(rec_x0[i]),
                  32'((exp_sw[i] % 2) ? eb : ea));
            if (i + 1 < rec_n)
                check($sformatf("%s.gap[%0d]", name, i), 32'(rec_cyc[i+1] - rec_cyc[i]),
                      32'(lat[i] + 3 + exp_clip[i]));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin : main
        rst = 1'b0; go = 1'b0; h_init = '0; t_end = '0; buf_a = '0; buf_b = '0;
        fill(V_OK, 4, 1);
        repeat (3) @(negedge clk);
        check("rst.init", 32'(sm_init), 32'd0);
        check("rst.start", 32'(sm_start), 32'd0);
        check("rst.read", 32'(sm_read_step), 32'd0);
        check("rst.step_in", 32'(sm_step_in), 32'd0);
        check("rst.x0", 32'(x0_address), 32'd0);
        check("rst.x1", 32'(x1_address), 32'd0);
        check("rst.t_now", 32'(t_now), 32'd0);
        check("rst.iter", 32'(iter_count), 32'd0);
        check("rst.flags", {29'd0, busy, finished, fail}, 32'd0);
        check("rst.code", 32'(fail_code), 32'd0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        fill(V_OK, 4, 1);              run_case("exact", 4, 12, 1'b0);
        fill(V_OK, 4, 2);              run_case("clip", 4, 10, 1'b0);
        fill(V_OK, 2, 1); verd[0] = V_REJ; verd[1] = V_REJ;
                                       run_case("retry2", 4, 2, 1'b0);
        fill(V_REJ, 2, 1);             run_case("retry4", 4, 20, 1'b0);
        fill(V_ERR, 4, 3);             run_case("smerr", 4, 20, 1'b0);
        fill(V_NEVER, 4, 1);           run_case("tmo", 4, 20, 1'b0);
        fill(V_OK, 4, 3);              run_case("go_busy", 4, 40, 1'b1);
        fill(V_OK, 0, 1);              run_case("zero_step", 5, 30, 1'b0);

        // Asynchronous reset in the middle of a WAIT
        fill(V_NEVER, 4, 1);
        h_init = 16'd6; t_end = 16'd50; buf_a = 4'd9; buf_b = 4'd3;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.x0", 32'(x0_address), 32'd0);
        check("arst.x1", 32'(x1_address), 32'd0);
        check("arst.step_in", 32'(sm_step_in), 32'd0);
        check("arst.pulses", {29'd0, sm_init, sm_start, sm_read_step}, 32'd0);
        check("arst.flags", {29'd0, busy, finished, fail}, 32'd0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                int p;
                p = int'($urandom_range(0, 99));
                verd[i] = (p < 80) ? V_OK : (p < 99) ? V_REJ : V_ERR;
                stp[i]  = ($urandom_range(0, 59) == 0) ? 0 : int'($urandom_range(1, 20));
                lat[i]  = int'($urandom_range(1, 4));
            end
            run_case($sformatf("rnd%0d", r), int'($urandom_range(1, 20)),
                     int'($urandom_range(0, 120)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
